// File: rtl/float2int_pipe.sv
// float2int_pipe: 3-stage IEEE-style float to saturating signed integer converter
// with round-to-nearest (ties away from zero), backpressure and a saturation counter.
module float2int_pipe #(
    parameter int MAN   = 23,
    parameter int EXP   = 8,
    parameter int OUT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [MAN+EXP:0]        in_float,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic [15:0]             sat_count
);
    localparam int BIAS = 2 ** (EXP - 1) - 1;
    localparam int SW = $clog2(OUT_W + 1);
    localparam logic [OUT_W:0] HALF = (OUT_W + 1)'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W - 1){1'b0}}};

    logic             adv;
    logic [EXP-1:0]   exp_f;
    logic [MAN-1:0]   man_f;
    logic             all_ones;
    int               ue;
    logic             v1, sign1, zero1, nan1, big1;
    logic [SW-1:0]    sh1;
    logic [MAN:0]     sig1;
    logic             v2, sign2, zero2, nan2, big2;
    logic [OUT_W:0]   x2;
    logic [OUT_W:0]   r;
    logic             sat3;
    logic [OUT_W-1:0] data3;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign exp_f    = in_float[MAN +: EXP];
    assign man_f    = in_float[MAN-1:0];
    assign all_ones = &exp_f;
    assign ue       = int'(exp_f) - BIAS;

    // x2 holds the magnitude times two (one fraction bit), so rounding is (x2+1)>>1
    assign r     = (OUT_W + 1)'(({1'b0, x2} + (OUT_W + 2)'(1)) >> 1);
    assign sat3  = nan2 || big2 || (!zero2 && (sign2 ? r > HALF : r >= HALF));
    assign data3 = (zero2 || nan2) ? '0 :
                   sat3 ? (sign2 ? MINV : MAXV) :
                   sign2 ? -r[OUT_W-1:0] : r[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            sign1     <= in_float[MAN+EXP];
            zero1     <= exp_f == '0 || ue < -1;
            nan1      <= all_ones && man_f != '0;
            big1      <= all_ones || ue >= OUT_W;
            sh1       <= SW'(ue + 1);
            sig1      <= {1'b1, man_f};
            v2        <= v1;
            sign2     <= sign1;
            zero2     <= zero1;
            nan2      <= nan1;
            big2      <= big1;
            x2        <= (OUT_W + 1)'(({{(OUT_W + 1){1'b0}}, sig1} << sh1) >> MAN);
            out_valid <= v2;
            out_sat   <= v2 && sat3;
            if (v2)
                out_data <= data3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
endmodule

// File: tb/tb_float2int_pipe.sv
// tb_float2int_pipe: directed table-driven checks plus stall, reset and counter-ceiling sequences.
module tb_float2int_pipe;
    logic               clk = 1'b0;
    logic               rst_n, in_valid, out_ready, in_ready, out_valid, out_sat;
    logic [31:0]        in_float;
    logic signed [22:0] out_data;
    logic [15:0]        sat_count;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 exp_cnt = 0;

    typedef struct {
        logic [31:0] f;
        logic [22:0] d;
        logic        s;
    } vec_t;
    vec_t tv[23];

    always #5 clk = ~clk;

    float2int_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_float(in_float),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_sat(out_sat), .sat_count(sat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, recv, cyc, hs, seen;
        logic [22:0] held;
        tv[0]  = '{32'h3F800000, 23'd1,       1'b0};
        tv[1]  = '{32'h3F000000, 23'd1,       1'b0};
        tv[2]  = '{32'hC0200000, 23'h7FFFFD,  1'b0};
        tv[3]  = '{32'h3EFFFFFF, 23'd0,       1'b0};
        tv[4]  = '{32'h4A800000, 23'h3FFFFF,  1'b1};
        tv[5]  = '{32'hCA800000, 23'h400000,  1'b0};
        tv[6]  = '{32'hFF800000, 23'h400000,  1'b1};
        tv[7]  = '{32'h7FC00000, 23'd0,       1'b1};
        tv[8]  = '{32'h00000001, 23'd0,       1'b0};
        tv[9]  = '{32'h7F800000, 23'h3FFFFF,  1'b1};
        tv[10] = '{32'h4A7FFFFF, 23'h3FFFFF,  1'b1};
        tv[11] = '{32'hCA7FFFFF, 23'h400000,  1'b0};
        tv[12] = '{32'hCA800001, 23'h400000,  1'b1};
        tv[13] = '{32'h40200000, 23'd3,       1'b0};
        tv[14] = '{32'h3FC00000, 23'd2,       1'b0};
        tv[15] = '{32'hBFC00000, 23'h7FFFFE,  1'b0};
        tv[16] = '{32'h40100000, 23'd2,       1'b0};
        tv[17] = '{32'hBF000000, 23'h7FFFFF,  1'b0};
        tv[18] = '{32'h49742400, 23'd1000000, 1'b0};
        tv[19] = '{32'h3F7FFFFF, 23'd1,       1'b0};
        tv[20] = '{32'hFFC00000, 23'd0,       1'b1};
        tv[21] = '{32'h4B000000, 23'h3FFFFF,  1'b1};
        tv[22] = '{32'h80000000, 23'd0,       1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_float = '0; out_ready = 1'b1;
        repeat (3) step();
        check("rst out_valid", out_valid, 0);
        check("rst out_data", $unsigned(out_data), 0);
        check("rst out_sat", out_sat, 0);
        check("rst sat_count", sat_count, 0);
        rst_n = 1'b1;
        step();
        check("in_ready after reset", in_ready, 1);

        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1; in_float = tv[i].f;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d lat1", i), out_valid, 0);
            step();
            check($sformatf("v%0d lat2", i), out_valid, 0);
            step();
            check($sformatf("v%0d valid", i), out_valid, 1);
            check($sformatf("v%0d data", i), $unsigned(out_data), tv[i].d);
            check($sformatf("v%0d sat", i), out_sat, tv[i].s);
            exp_cnt += int'(tv[i].s);
            step();
            check($sformatf("v%0d sat_count", i), sat_count, exp_cnt);
            check($sformatf("v%0d drained", i), out_valid, 0);
        end

        sent = 0; recv = 0; cyc = 0; held = '0;
        while (recv < 10 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            in_valid = sent < 10;
            in_float = tv[sent < 10 ? sent : 0].f;
            #1;
            if (!out_ready) begin
                check($sformatf("bp stall in_ready c%0d", cyc), in_ready, 0);
                check($sformatf("bp stall valid c%0d", cyc), out_valid, 1);
                if (cyc > 5)
                    check($sformatf("bp stall hold c%0d", cyc), $unsigned(out_data), held);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp data %0d", recv), $unsigned(out_data), tv[recv].d);
                check($sformatf("bp sat %0d", recv), out_sat, tv[recv].s);
                exp_cnt += int'(tv[recv].s);
                recv++;
            end
            if (in_valid && in_ready)
                sent++;
            held = out_data;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp received", recv, 10);
        check("bp sat_count", sat_count, exp_cnt);
        seen = 0;
        repeat (4) begin
            step();
            if (out_valid) seen++;
        end
        check("bp no duplicate", seen, 0);

        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_float = 32'h4A800000;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("mid in flight", out_valid, 1);
        check("mid pre-reset count", sat_count, exp_cnt);
        rst_n = 1'b0;
        step();
        check("mid rst out_valid", out_valid, 0);
        check("mid rst sat_count", sat_count, 0);
        check("mid rst out_data", $unsigned(out_data), 0);
        check("mid rst out_sat", out_sat, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (out_valid) seen++;
        end
        check("mid no ghost output", seen, 0);

        in_valid = 1'b1; in_float = 32'hFF800000; out_ready = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 65540 && cyc < 70000) begin
            if (hs < 3 || hs > 65532)
                check($sformatf("ceil count hs%0d", hs), sat_count, hs > 65535 ? 65535 : hs);
            if (out_valid && out_ready && out_sat)
                hs++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("ceil handshakes", hs, 65540);
        check("ceil final", sat_count, 16'hFFFF);
        repeat (4) step();
        check("ceil held", sat_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/float2int_pipe.md
FLOAT2INT_PIPE -- requirements
Module: float2int_pipe

Interface
REQ-001 SHALL have parameter MAN, default 23, meaning the mantissa width of the float input.
REQ-002 SHALL have parameter EXP, default 8, meaning the exponent width of the float input; bias = 2^(EXP-1)-1.
REQ-003 SHALL have parameter OUT_W, default 23, meaning the signed integer output width.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 Ports, name / direction / width / meaning:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_float is valid this cycle
- in_float  in  MAN+EXP+1  float sample {sign, exp, man}, e.g. an IIR y_float
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  out_data is valid
- out_data  out  OUT_W  signed converted sample
- out_ready  in  1  downstream accepts out_data
- out_sat  out  1  the current out_data was saturated or came from NaN
- sat_count  out  16  count of saturated/NaN samples delivered

Function
REQ-006 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 align shift, S3 round/saturate; latency 3 cycles from accepting a sample to out_valid with no stall.
REQ-007 SHALL accept a sample on a clock edge when in_valid and in_ready are both 1.
REQ-008 SHALL stall all stages when out_valid=1 and out_ready=0; in_ready = NOT that condition.
REQ-009 SHALL advance all stages when out_ready=1, with bubbles propagating as valid=0 (full throughput of 1 sample/cycle).
REQ-010 SHALL hold out_data, out_sat and out_valid stable while stalled.
REQ-011 SHALL convert finite inputs with round-to-nearest, ties away from zero.
REQ-012 SHALL map exp=0 (zero/denormal) to out_data=0, out_sat=0.
REQ-013 SHALL map an unbiased exponent < -1 to 0; an unbiased exponent of -1 rounds to +/-1.
REQ-014 SHALL saturate positive results > 2^(OUT_W-1)-1 to 2^(OUT_W-1)-1 and negative results < -2^(OUT_W-1) to -2^(OUT_W-1), with out_sat=1; this includes overflow caused by rounding.
REQ-015 SHALL pass -2^(OUT_W-1) exactly, with out_sat=0.
REQ-016 SHALL map infinity (exp all ones, man=0) to the signed saturation limit with out_sat=1.
REQ-017 SHALL map NaN (exp all ones, man!=0) to 0 with out_sat=1.
REQ-018 SHALL increment sat_count once per handshake (out_valid and out_ready) with out_sat=1, saturating at 16'hFFFF with no wrap.
REQ-019 SHALL not count a stalled sample more than once.

Reset
REQ-020 While rst_n=0 at a rising edge, SHALL clear all stage valids, out_valid, out_data, out_sat and sat_count to 0.
REQ-021 SHALL drive in_ready=1 in the cycle after reset deasserts.
REQ-022 SHALL discard samples in flight when reset asserts mid-operation; no output for them after reset.
REQ-023 Datapath registers without valid qualification need not be reset, but out_data SHALL read 0 after reset.

Verification
REQ-024 Basic values (OUT_W=23), out_ready=1: 0x3F800000 -> 1; 0x3F000000 -> 1; 0xC0200000 -> -3; 0x3EFFFFFF -> 0; each appears 3 cycles after acceptance, out_sat=0.
REQ-025 Saturation: 0x4A800000 (2^22) -> 4194303, out_sat=1, sat_count increments by 1; 0xCA800000 -> -4194304, out_sat=0; 0xFF800000 -> -4194304, out_sat=1.
REQ-026 NaN: 0x7FC00000 -> 0, out_sat=1; 0x00000001 (denormal) -> 0, out_sat=0.
REQ-027 Backpressure: stream 10 back-to-back samples, with out_ready held low for 4 cycles mid-stream -> no loss or duplication, order preserved, in_ready=0 during the stall, and sat_count counts each saturated sample exactly once.
REQ-028 Reset mid-stream: rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 and sat_count=0 next cycle, and none of the 3 samples emerges.
REQ-029 Counter ceiling: force 65536 saturated handshakes -> sat_count=16'hFFFF and it stays there.
